// File: rtl/division_arbiter.sv
// Round-robin arbiter that shares one iterative divider among N requesters.
// Divide-by-zero is answered locally; a watchdog aborts a divider that never reports ready.
module division_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned W       = 64,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req,
   input  logic [N*W-1:0]   dividend_in,
   input  logic [N*W-1:0]   divisor_in,
   output logic [N-1:0]     ack,
   output logic [N-1:0]     done,
   output logic [W-1:0]     quotient_out,
   output logic [W-1:0]     remainder_out,
   output logic             div_by_zero,
   output logic             timeout_err,
   output logic             busy,
   output logic [W-1:0]     div_dividend,
   output logic [W-1:0]     div_divisor,
   output logic             div_start,
   input  logic             div_ready,
   input  logic [W-1:0]     div_quotient,
   input  logic [W-1:0]     div_remainder
);

   localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {StIdle, StIssue, StZero, StWait, StResp} state_e;

   state_e          state_q, state_d;
   logic [LW-1:0]   last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    ack_q, ack_d, done_q, done_d;
   logic [W-1:0]    quot_q, quot_d, rem_q, rem_d;
   logic [W-1:0]    dvd_q, dvd_d, dvs_q, dvs_d;
   logic            start_q, start_d, dbz_q, dbz_d, to_q, to_d, busy_q, busy_d;

   logic [W-1:0]    dvd_arr [N];
   logic [W-1:0]    dvs_arr [N];
   logic [LW-1:0]   idx, win;
   logic            found;

   always_comb begin
      for (int i = 0; i < int'(N); i++) begin
         dvd_arr[i] = dividend_in[i*W +: W];
         dvs_arr[i] = divisor_in[i*W +: W];
      end
   end

   // Search last+1, last+2, ... modulo N; first raised request wins.
   always_comb begin
      win   = last_q;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= int'(N); k++) begin
         idx = LW'((int'(last_q) + k) % int'(N));
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      ack_d   = '0;
      done_d  = '0;
      start_d = 1'b0;
      dbz_d   = 1'b0;
      to_d    = 1'b0;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;

      case (state_q)
         StIdle: begin
            if (found) begin
               last_d     = win;
               dvd_d      = dvd_arr[win];
               dvs_d      = dvs_arr[win];
               ack_d[win] = 1'b1;
               if (dvs_arr[win] == '0) begin
                  state_d = StZero;
               end else begin
                  state_d = StIssue;
                  start_d = 1'b1;
               end
            end
         end
         StIssue: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            cnt_d = cnt_q + 1'b1;
            // First WAIT cycle ignores ready: it is still the divider's idle flag.
            if (cnt_q != '0 && div_ready) begin
               quot_d         = div_quotient;
               rem_d          = div_remainder;
               done_d[last_q] = 1'b1;
               state_d        = StResp;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               quot_d         = '0;
               rem_d          = '0;
               to_d           = 1'b1;
               done_d[last_q] = 1'b1;
               state_d        = StResp;
            end
         end
         StZero: begin
            quot_d         = '1;
            rem_d          = dvd_q;
            dbz_d          = 1'b1;
            done_d[last_q] = 1'b1;
            state_d        = StResp;
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         last_q  <= LW'(N - 1);
         cnt_q   <= '0;
         ack_q   <= '0;
         done_q  <= '0;
         start_q <= 1'b0;
         dbz_q   <= 1'b0;
         to_q    <= 1'b0;
         busy_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         done_q  <= done_d;
         start_q <= start_d;
         dbz_q   <= dbz_d;
         to_q    <= to_d;
         busy_q  <= busy_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
      end
   end

   assign ack           = ack_q;
   assign done          = done_q;
   assign div_start     = start_q;
   assign div_by_zero   = dbz_q;
   assign timeout_err   = to_q;
   assign busy          = busy_q;
   assign quotient_out  = quot_q;
   assign remainder_out = rem_q;
   assign div_dividend  = dvd_q;
   assign div_divisor   = dvs_q;

endmodule

// File: doc/division_arbiter.md
Name: division_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 64-bit iterative divider (division_top) among N requesters.
- Accepts operand pairs from requesters and handles divide-by-zero locally, without using the divider.
- Launches the divider with a one-cycle start, waits for ready, and returns quotient/remainder to the owning requester with a done pulse.
- A watchdog aborts transactions whose divider never reports ready.

Parameters:
- N, 4, number of requesters (≥2).
- W, 64, operand/result width; must match the divider.
- TIMEOUT, 256, maximum WAIT cycles before abort (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  N  per-requester request; held high with stable operands until ack.
- dividend_in  input  N*W  packed dividends, requester i at [i*W +: W].
- divisor_in  input  N*W  packed divisors, same packing.
- ack  output  N  one-hot, one-cycle pulse: operands of requester i captured.
- done  output  N  one-hot, one-cycle pulse: result for requester i valid.
- quotient_out  output  W  result quotient; valid with done, held until next done.
- remainder_out  output  W  result remainder; same validity rule.
- div_by_zero  output  1  high with done when divisor was 0.
- timeout_err  output  1  high with done when watchdog aborted.
- busy  output  1  high in every state except IDLE.
- div_dividend  output  W  divider operand; registered, stable for the whole transaction.
- div_divisor  output  W  divider operand; registered, same rule.
- div_start  output  1  one-cycle start pulse to divider.
- div_ready  input  1  divider result-valid/idle flag.
- div_quotient  input  W  divider quotient.
- div_remainder  input  W  divider remainder.

Behaviour:
- All outputs registered. Reset values:
  - state = IDLE; ack, done, div_start, busy, div_by_zero, timeout_err = 0.
  - quotient_out, remainder_out, div_dividend, div_divisor = 0.
  - Round-robin pointer last = N-1, so requester 0 has top priority first.
- States: IDLE, ISSUE, ZERO, WAIT, RESP.
- IDLE, on an edge with any req high:
  - Winner = first requester with req high, searching last+1, last+2, … modulo N; set last = winner.
  - Latch the winner's operands into div_dividend/div_divisor.
  - Next cycle ack[winner] = 1.
  - Go to ZERO if the latched divisor == 0, else ISSUE.
  - With no req, stay in IDLE.
- ISSUE (1 cycle): div_start = 1, ack pulse concurrent; clear wait counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - div_ready is ignored in the first WAIT cycle (counter == 0), which masks the divider's stale idle-ready.
  - When counter ≥ 1 and div_ready = 1: capture div_quotient/div_remainder, go to RESP.
  - When counter reaches TIMEOUT-1 without a qualifying ready: result = 0/0, flag timeout, go to RESP.
  - div_ready wins if it coincides with the timeout cycle.
- ZERO (1 cycle, ack pulse concurrent): result quotient = all ones, remainder = latched dividend, flag div_by_zero; go to RESP. The divider is never started.
- RESP (1 cycle):
  - done[owner] = 1; quotient_out/remainder_out update.
  - div_by_zero/timeout_err valid for this cycle only, otherwise 0.
  - Go to IDLE.
- Latency:
  - Request sampled at edge E0 → ack and div_start in cycle after E0.
  - done = divider latency + 3 cycles after E0.
  - Zero path: done 2 cycles after E0.
  - At least one IDLE cycle between transactions.
- Requests:
  - req may drop after ack; requests arriving during busy wait until IDLE.
  - req still high in IDLE after done is a new request.
  - Operand changes after ack are ignored.
- Reset mid-operation: in-flight transaction discarded, no done issued, div_start low the next cycle, pointer reset.
- Only one of ack/done/div_start bits is ever asserted per bus (one-hot or zero).

Test Plan:
- Single requester: req0 with 17/27 → ack[0] one cycle with div_start, later done[0] with q = 0, r = 17; busy high throughout.
- Simultaneous arbitration: req0 (100/7) and req2 (50/5) raised the same cycle → done[0] q = 14 r = 2 first, then done[2] q = 10 r = 0.
- Fairness: all four req held continuously → grant order 0, 1, 2, 3, 0, 1; no requester granted twice before the others.
- Divide-by-zero: req1 with 42/0 → div_start never asserts; done[1] 2 cycles after sampling with q = 0xFFFF_FFFF_FFFF_FFFF, r = 42, div_by_zero = 1.
- Timeout and stale ready: divider stub holds ready high then low forever, TIMEOUT = 8 → stale ready ignored; done with timeout_err = 1, q = r = 0, 8 WAIT cycles.
- Reset mid-WAIT: reset asserted during WAIT → next cycle busy = 0, no done; a fresh req0 after reset is granted before req3.
